alu_div_iter: RTL and testbench

//  Iterative radix-2 restoring divider implementing RV32M DIV/DIVU/REM/REMU.

---
 rtl/alu_div_iter.sv | 146 ++++++++++++++
 tb/tb_alu_div_iter.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_div_iter.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional early-out when |b| > |a|: define DIV_EARLY_OUT_EN.
module alu_div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] opranda,
    input  logic [XLEN-1:0] oprandb,
    input  logic            unsigned_flag,
    input  logic            rem_flag,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] div_res
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]   count;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;
    logic            q_neg;
    logic            r_neg;
    logic            rem_sel;

    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, ovf, early, fast;
    logic            accept, last;
    logic [XLEN:0]   rem_sh, rem_sub;
    logic            ge;
    logic [XLEN-1:0] rem_new, quo_new;
    logic [XLEN-1:0] fast_res, calc_res;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready & ~kill;
    assign last      = (count == CW'(XLEN - 1));

    assign a_neg = ~unsigned_flag & opranda[XLEN-1];
    assign b_neg = ~unsigned_flag & oprandb[XLEN-1];
    assign a_mag = a_neg ? -opranda : opranda;
    assign b_mag = b_neg ? -oprandb : oprandb;

    assign div_zero = (oprandb == '0);
    assign ovf      = ~unsigned_flag
                    & (opranda == {1'b1, {(XLEN-1){1'b0}}})
                    & (oprandb == '1);
`ifdef DIV_EARLY_OUT_EN
    assign early = (b_mag > a_mag);
`else
    assign early = 1'b0;
`endif
    assign fast = div_zero | ovf | early;

    // Remainder is XLEN+1 wide after the shift, so compare one bit wider.
    assign rem_sh  = {rem_q, quo_q[XLEN-1]};
    assign rem_sub = rem_sh - {1'b0, dvs_q};
    assign ge      = ~rem_sub[XLEN];
    assign rem_new = ge ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
    assign quo_new = {quo_q[XLEN-2:0], ge};

    // Result for ops that bypass the iterative loop.
    always_comb begin
        fast_res = '0;
        if (div_zero)
            fast_res = rem_flag ? opranda : '1;
        else if (ovf)
            fast_res = rem_flag ? '0 : opranda;
        else
            fast_res = rem_flag ? opranda : '0;
    end

    // Sign fix-up on the final iteration's values.
    always_comb begin
        calc_res = '0;
        if (rem_sel)
            calc_res = r_neg ? -rem_new : rem_new;
        else
            calc_res = q_neg ? -quo_new : quo_new;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; kill overrides every transition.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = fast ? DONE : CALC;
            CALC: if (last) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (kill)
            state_nxt = IDLE;
    end

    // Operand latch, one quotient bit per CALC cycle, result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            rem_sel <= 1'b0;
            div_res <= '0;
        end else if (accept) begin
            count   <= '0;
            rem_q   <= '0;
            quo_q   <= a_mag;
            dvs_q   <= b_mag;
            q_neg   <= a_neg ^ b_neg;
            r_neg   <= a_neg;
            rem_sel <= rem_flag;
            if (fast)
                div_res <= fast_res;
        end else if (state == CALC && !kill) begin
            rem_q <= rem_new;
            quo_q <= quo_new;
            count <= count + 1'b1;
            if (last)
                div_res <= calc_res;
        end
    end

endmodule

// File: tb/tb_alu_div_iter.sv
// Directed self-checking bench for alu_div_iter.
// Expected values are hand-computed for XLEN=32.
module tb_alu_div_iter;

    localparam int XLEN = 32;

`ifdef DIV_EARLY_OUT_EN
    localparam int LAT_SMALL = 1;
`else
    localparam int LAT_SMALL = XLEN + 1;
`endif

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] opranda;
    logic [XLEN-1:0] oprandb;
    logic            unsigned_flag;
    logic            rem_flag;
    logic            kill;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] div_res;

    int n_cmp;
    int n_bad;

    alu_div_iter #(.XLEN(XLEN)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .opranda       (opranda),
        .oprandb       (oprandb),
        .unsigned_flag (unsigned_flag),
        .rem_flag      (rem_flag),
        .kill          (kill),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .div_res       (div_res)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Issue one op, wait (bounded) for out_valid, then complete handshake.
    // lat counts edges from the accept edge (inclusive) to out_valid.
    task automatic run_op(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic uf, input logic rf,
                          output int lat, output logic [XLEN-1:0] res);
        opranda       = a;
        oprandb       = b;
        unsigned_flag = uf;
        rem_flag      = rf;
        in_valid      = 1'b1;
        out_ready     = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = div_res;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        n_cmp++;
        if (div_res !== '0) begin
            n_bad++;
            $display("FAIL reset_div_res got %h want 0", div_res);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_unsigned();
        int lat;
        logic [XLEN-1:0] r;
        run_op(32'd100, 32'd7, 1'b1, 1'b0, lat, r);
        n_cmp++;
        if (r !== 32'd14) begin
            n_bad++;
            $display("FAIL divu_100_7 got %h want %h", r, 32'd14);
        end
        n_cmp++;
        if (lat !== XLEN + 1) begin
            n_bad++;
            $display("FAIL divu_latency got %0d want %0d", lat, XLEN + 1);
        end
        run_op(32'd100, 32'd7, 1'b1, 1'b1, lat, r);
        n_cmp++;
        if (r !== 32'd2) begin
            n_bad++;
            $display("FAIL remu_100_7 got %h want 2", r);
        end
        run_op(32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, lat, r);
        n_cmp++;
        if (r !== 32'd1) begin
            n_bad++;
            $display("FAIL divu_big got %h want 1", r);
        end
        run_op(32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, lat, r);
        n_cmp++;
        if (r !== 32'h7FFF_FFFF) begin
            n_bad++;
            $display("FAIL remu_big got %h want 7fffffff", r);
        end
    endtask

    task automatic test_signed();
        int lat;
        logic [XLEN-1:0] r;
        run_op(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, lat, r);
        n_cmp++;
        if (r !== 32'hFFFF_FFFF) begin
            n_bad++;
            $display("FAIL rem_m7_2 got %h want ffffffff", r);
        end
        run_op(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, lat, r);
        n_cmp++;
        if (r !== 32'hFFFF_FFFD) begin
            n_bad++;
            $display("FAIL div_m7_2 got %h want fffffffd", r);
        end
        n_cmp++;
        if (lat !== XLEN + 1) begin
            n_bad++;
            $display("FAIL div_signed_latency got %0d want %0d", lat, XLEN + 1);
        end
        run_op(32'd7, 32'hFFFF_FFFE, 1'b0, 1'b1, lat, r);
        n_cmp++;
        if (r !== 32'd1) begin
            n_bad++;
            $display("FAIL rem_7_m2 got %h want 1", r);
        end
        run_op(32'h8000_0000, 32'd2, 1'b0, 1'b0, lat, r);
        n_cmp++;
        if (r !== 32'hC000_0000) begin
            n_bad++;
            $display("FAIL div_min_2 got %h want c0000000", r);
        end
    endtask

    task automatic test_overflow();
        int lat;
        logic [XLEN-1:0] r;
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, lat, r);
        n_cmp++;
        if (r !== 32'h8000_0000) begin
            n_bad++;
            $display("FAIL ovf_div got %h want 80000000", r);
        end
        n_cmp++;
        if (lat !== 1) begin
            n_bad++;
            $display("FAIL ovf_latency got %0d want 1", lat);
        end
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, lat, r);
        n_cmp++;
        if (r !== 32'd0) begin
            n_bad++;
            $display("FAIL ovf_rem got %h want 0", r);
        end
    endtask

    task automatic test_div_zero();
        int lat;
        logic [XLEN-1:0] r;
        run_op(32'd5, 32'd0, 1'b1, 1'b0, lat, r);
        n_cmp++;
        if (r !== 32'hFFFF_FFFF) begin
            n_bad++;
            $display("FAIL divu_by0 got %h want ffffffff", r);
        end
        n_cmp++;
        if (lat !== 1) begin
            n_bad++;
            $display("FAIL divu_by0_latency got %0d want 1", lat);
        end
        run_op(32'd5, 32'd0, 1'b1, 1'b1, lat, r);
        n_cmp++;
        if (r !== 32'd5) begin
            n_bad++;
            $display("FAIL remu_by0 got %h want 5", r);
        end
        n_cmp++;
        if (lat !== 1) begin
            n_bad++;
            $display("FAIL remu_by0_latency got %0d want 1", lat);
        end
        run_op(32'hFFFF_FFFB, 32'd0, 1'b0, 1'b1, lat, r);
        n_cmp++;
        if (r !== 32'hFFFF_FFFB) begin
            n_bad++;
            $display("FAIL rem_by0_neg got %h want fffffffb", r);
        end
    endtask

    task automatic test_hold();
        int lat;
        opranda       = 32'd100;
        oprandb       = 32'd7;
        unsigned_flag = 1'b1;
        rem_flag      = 1'b0;
        in_valid      = 1'b1;
        out_ready     = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_busy_in_ready got %b want 0", in_ready);
        end
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (out_valid !== 1'b1 || div_res !== 32'd14 || in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL hold_cycle%0d got v=%b r=%h rdy=%b want v=1 r=0000000e rdy=0",
                         i, out_valid, div_res, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL hold_release got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
        n_cmp++;
        if (div_res !== 32'd14) begin
            n_bad++;
            $display("FAIL idle_keeps_res got %h want 0000000e", div_res);
        end
    endtask

    task automatic test_kill();
        int seen;
        // kill in IDLE blocks a divide-by-zero that would finish next edge
        opranda       = 32'd5;
        oprandb       = 32'd0;
        unsigned_flag = 1'b1;
        rem_flag      = 1'b0;
        in_valid      = 1'b1;
        kill          = 1'b1;
        out_ready     = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        kill     = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL kill_idle got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
        // kill at CALC cycle 10
        opranda   = 32'd100;
        oprandb   = 32'd7;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL kill_calc got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
        end
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid)
                seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL kill_no_result got %0d valid cycles want 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        opranda       = 32'd100;
        oprandb       = 32'd7;
        unsigned_flag = 1'b1;
        rem_flag      = 1'b0;
        in_valid      = 1'b1;
        out_ready     = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_cmp++;
        if (out_valid !== 1'b0 || div_res !== '0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid got v=%b r=%h rdy=%b want v=0 r=0 rdy=1",
                     out_valid, div_res, in_ready);
        end
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid)
                seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL reset_mid_no_result got %0d valid cycles want 0", seen);
        end
    endtask

    task automatic test_small();
        int lat;
        logic [XLEN-1:0] r;
        run_op(32'd3, 32'd9, 1'b1, 1'b0, lat, r);
        n_cmp++;
        if (r !== 32'd0) begin
            n_bad++;
            $display("FAIL divu_3_9 got %h want 0", r);
        end
        n_cmp++;
        if (lat !== LAT_SMALL) begin
            n_bad++;
            $display("FAIL divu_3_9_latency got %0d want %0d", lat, LAT_SMALL);
        end
        run_op(32'd3, 32'd9, 1'b1, 1'b1, lat, r);
        n_cmp++;
        if (r !== 32'd3) begin
            n_bad++;
            $display("FAIL remu_3_9 got %h want 3", r);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [XLEN-1:0] r;
        run_op(32'd1000, 32'd10, 1'b1, 1'b0, lat, r);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_ready got %b want 1", in_ready);
        end
        n_cmp++;
        if (r !== 32'd100) begin
            n_bad++;
            $display("FAIL b2b_first got %h want 00000064", r);
        end
        run_op(32'd1001, 32'd10, 1'b1, 1'b1, lat, r);
        n_cmp++;
        if (r !== 32'd1) begin
            n_bad++;
            $display("FAIL b2b_second got %h want 1", r);
        end
    endtask

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        opranda       = '0;
        oprandb       = '0;
        unsigned_flag = 1'b0;
        rem_flag      = 1'b0;
        kill          = 1'b0;
        out_ready     = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_overflow();
        test_div_zero();
        test_hold();
        test_kill();
        test_reset_mid();
        test_small();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
